// File: rtl/booth_mul_seq_pkg.sv
// Shared ALU definitions for the sequential Booth multiplier: operand width,
// controller states and the radix-4 Booth digit decode.
package alu_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_e;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      POS1 = 3'd1,
      POS2 = 3'd2,
      NEG1 = 3'd3,
      NEG2 = 3'd4
   } booth_op_e;

   // Window is {b[i+1], b[i], b[i-1]}; digit = -2*b[i+1] + b[i] + b[i-1].
   function automatic booth_op_e booth_decode(input logic [2:0] window);
      booth_op_e op;
      case (window)
         3'b000, 3'b111: op = ZERO;
         3'b001, 3'b010: op = POS1;
         3'b011:         op = POS2;
         3'b100:         op = NEG2;
         3'b101, 3'b110: op = NEG1;
         default:        op = ZERO;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// Request/response bundle between the control unit and the Booth multiplier.
interface booth_mul_seq_if #(parameter int WIDTH = alu_pkg::WIDTH);
   logic               start;
   logic [WIDTH-1:0]   A;
   logic [WIDTH-1:0]   B;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] Z;

   modport master (output start, output A, output B,
                   input busy, input done, input Z);
   modport slave  (input start, input A, input B,
                   output busy, output done, output Z);
endinterface

// File: rtl/booth_mul_seq_recode.sv
// Radix-4 Booth recoder: turns a 3-bit multiplier window into sign,
// doubling and zero controls for the partial-product select.
module booth_recode
   import alu_pkg::*;
(
   input  logic [2:0] i_window,
   output logic       o_neg,
   output logic       o_two,
   output logic       o_zero
);
   booth_op_e w_op;

   // Decode the window and fan the digit out into the three controls.
   always_comb begin
      w_op   = booth_decode(i_window);
      o_neg  = (w_op == NEG1) || (w_op == NEG2);
      o_two  = (w_op == POS2) || (w_op == NEG2);
      o_zero = (w_op == ZERO);
   end
endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed WIDTHxWIDTH multiplier, radix-4 Booth, two multiplier bits
// per clock; result packed {HI, LO} and presented with a one-cycle done pulse.
module booth_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = alu_pkg::WIDTH
)(
   input  logic              clock,
   input  logic              reset_n,
   booth_mul_seq_if.slave    bus
);
   localparam int STEPS = WIDTH / 2;
   localparam int CW    = $clog2(STEPS);
   localparam int PW    = WIDTH + 2;

   mul_state_e          r_state;
   mul_state_e          w_state_nxt;
   logic [CW-1:0]       r_cnt;
   logic [PW-1:0]       r_m;
   logic [PW-1:0]       r_p_hi;
   logic [WIDTH-1:0]    r_p_lo;
   logic                r_q;
   logic [2*WIDTH-1:0]  r_z;
   logic                r_busy;
   logic                r_done;

   logic                w_neg;
   logic                w_two;
   logic                w_zero;
   logic [PW-1:0]       w_mag;
   logic [PW-1:0]       w_addend;
   logic [PW-1:0]       w_sum;
   logic [PW-1:0]       w_hi_nxt;
   logic [WIDTH-1:0]    w_lo_nxt;
   logic                w_last;

   booth_recode u_recode (
      .i_window ({r_p_lo[1:0], r_q}),
      .o_neg    (w_neg),
      .o_two    (w_two),
      .o_zero   (w_zero)
   );

   // Booth step: select +/-M or +/-2M, accumulate, then arithmetic shift by 2.
   always_comb begin
      w_mag    = {PW{1'b0}};
      w_addend = {PW{1'b0}};
      if (w_zero) begin
         w_mag = {PW{1'b0}};
      end else if (w_two) begin
         w_mag = {r_m[PW-2:0], 1'b0};
      end else begin
         w_mag = r_m;
      end
      if (w_neg) begin
         w_addend = ~w_mag + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         w_addend = w_mag;
      end
      w_sum    = r_p_hi + w_addend;
      w_hi_nxt = {{2{w_sum[PW-1]}}, w_sum[PW-1:2]};
      w_lo_nxt = {w_sum[1:0], r_p_lo[WIDTH-1:2]};
      w_last   = (r_cnt == CW'(STEPS - 1));
   end

   // Controller next state; start is only honoured outside RUN.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (bus.start) w_state_nxt = RUN;
            else           w_state_nxt = IDLE;
         end
         RUN: begin
            if (w_last) w_state_nxt = DONE;
            else        w_state_nxt = RUN;
         end
         DONE: begin
            if (bus.start) w_state_nxt = RUN;
            else           w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register plus registered status flags derived from the next state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == RUN);
         r_done  <= (w_state_nxt == DONE);
      end
   end

   // Operand capture, iteration and result latch; Z moves only on completion.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= {CW{1'b0}};
         r_m    <= {PW{1'b0}};
         r_p_hi <= {PW{1'b0}};
         r_p_lo <= {WIDTH{1'b0}};
         r_q    <= 1'b0;
         r_z    <= {(2*WIDTH){1'b0}};
      end else if (r_state == RUN) begin
         r_p_hi <= w_hi_nxt;
         r_p_lo <= w_lo_nxt;
         r_q    <= r_p_lo[1];
         r_cnt  <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
         if (w_last) begin
            r_z <= {w_hi_nxt[WIDTH-1:0], w_lo_nxt};
         end else begin
            r_z <= r_z;
         end
      end else if (bus.start) begin
         r_m    <= {{2{bus.A[WIDTH-1]}}, bus.A};
         r_p_hi <= {PW{1'b0}};
         r_p_lo <= bus.B;
         r_q    <= 1'b0;
         r_cnt  <= {CW{1'b0}};
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.Z    = r_z;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Randomized self-checking bench for booth_mul_seq against a cycle-timed
// arithmetic model of the multiplier.
module tb_booth_mul_seq;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   booth_mul_seq_if #(.WIDTH(32)) bus();

   booth_mul_seq dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: result appears 16 edges after the accepted start edge.
   int          m_cnt;
   logic [63:0] m_pend;
   logic [63:0] m_z;
   logic        m_done;
   logic        m_busy;
   int          m_done_cnt;
   int          d_done_cnt;

   function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= 0;
         m_pend <= 64'd0;
         m_z    <= 64'd0;
         m_done <= 1'b0;
         m_busy <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_z    <= m_pend;
               m_done <= 1'b1;
               m_busy <= 1'b0;
            end
         end else if (bus.start) begin
            m_pend <= smul(bus.A, bus.B);
            m_cnt  <= 16;
            m_busy <= 1'b1;
         end
      end
   end

   task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      check64("busy", {63'd0, bus.busy}, {63'd0, m_busy});
      check64("done", {63'd0, bus.done}, {63'd0, m_done});
      check64("Z", bus.Z, m_z);
      if (bus.busy && bus.done) begin
         n_errors = n_errors + 1;
         $display("FAIL busy_and_done: both high at %0t", $time);
      end
      if (bus.done) d_done_cnt = d_done_cnt + 1;
      if (m_done)   m_done_cnt = m_done_cnt + 1;
   end

   task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] lit);
      bit seen;
      @(negedge clk);
      bus.A = a; bus.B = b; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.A = $urandom; bus.B = $urandom;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (bus.done) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) begin
         n_checks = n_checks + 1;
         n_errors = n_errors + 1;
         $display("FAIL %s_timeout: no done within 40 cycles", name);
      end else begin
         check64(name, bus.Z, lit);
         check64({name, "_model"}, m_z, lit);
      end
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0; n_errors = 0; m_done_cnt = 0; d_done_cnt = 0;
      bus.start = 1'b0; bus.A = 32'd0; bus.B = 32'd0;
      rst_n = 1'b0;
      #12;
      check64("reset_Z", bus.Z, 64'd0);
      check64("reset_busy", {63'd0, bus.busy}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      directed("m7xm3", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
      directed("min_sq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      directed("max_sq", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
      directed("min_x1", 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000);
      directed("zero", 32'h0000_0000, 32'h1234_5678, 64'd0);
      directed("m1xmin", 32'hFFFF_FFFF, 32'h8000_0000, 64'h0000_0000_8000_0000);

      // Random operands and start pulses, operands changing every cycle.
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         bus.A = $urandom;
         bus.B = $urandom;
         bus.start = ($urandom_range(0, 2) == 0);
      end

      // start held high: back-to-back results every 17 cycles.
      for (int i = 0; i < 600 * 17; i++) begin
         @(negedge clk);
         bus.A = $urandom;
         bus.B = $urandom;
         bus.start = 1'b1;
      end
      @(negedge clk);
      bus.start = 1'b0;
      repeat (20) @(negedge clk);

      // Asynchronous reset in the middle of an operation.
      directed("pre_rst", 32'h0001_0003, 32'h0002_0005, 64'h0000_0002_000B_000F);
      bus.A = 32'h1111_1111; bus.B = 32'h2222_2222; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check64("async_busy", {63'd0, bus.busy}, 64'd0);
      check64("async_done", {63'd0, bus.done}, 64'd0);
      check64("async_Z", bus.Z, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      directed("post_rst", 32'hFFFF_FFF9, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFD6);

      check64("done_count", 64'(d_done_cnt), 64'(m_done_cnt));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
